// File: rtl/mtm_ser_pkg.sv
// rtl/mtm_ser_pkg.sv - shared states and constants for the ALU packet serializer; MTM_SER_PARITY_EN selects 12-bit frames
package mtm_ser_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_FLAG,
      S_PAYLOAD,
      S_PARITY,
      S_STOP,
      S_GAP
   } state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic FLAG_DATA = 1'b0;
   localparam logic FLAG_CTL  = 1'b1;

`ifdef MTM_SER_PARITY_EN
   localparam int FRAME_BITS = 12;
`else
   localparam int FRAME_BITS = 11;
`endif

   localparam int CTL_ERR_BIT = 7;

   // Even parity: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/mtm_ser_bit_tick.sv
// rtl/mtm_ser_bit_tick.sv - CLK_PER_BIT divider giving a one-cycle strobe on the last cycle of each serial bit
module mtm_ser_bit_tick #(
   parameter int CLK_PER_BIT = 1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int            TW   = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST = TW'(CLK_PER_BIT - 1);

   logic [TW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LAST);

   // Count clocks within the current bit; restart on a new packet.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + TW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mtm_alu_pkt_serializer.sv
// rtl/mtm_alu_pkt_serializer.sv - framed serial output of ALU result words; MTM_SER_PARITY_EN adds an even-parity bit per frame
module mtm_alu_pkt_serializer
   import mtm_ser_pkg::*;
#(
   parameter int DATA_BYTES  = 4,
   parameter int CLK_PER_BIT = 1,
   parameter int IFG_BITS    = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*DATA_BYTES-1:0] in_data,
   input  logic [7:0]              in_ctl,
   output logic                    sout,
   output logic                    busy,
   output logic                    done
);

   localparam int            FW       = $clog2(DATA_BYTES + 1);
   localparam int            GW       = (IFG_BITS > 1) ? $clog2(IFG_BITS) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((IFG_BITS > 0) ? IFG_BITS - 1 : 0);

   state_e                  state_q, state_d;
   logic                    sout_q, sout_d;
   logic [2:0]              bit_idx_q, bit_idx_d;
   logic [FW-1:0]           frame_q, frame_d;
   logic [GW-1:0]           gap_q, gap_d;
   logic [8*DATA_BYTES-1:0] data_q, data_d;
   logic [7:0]              ctl_q, ctl_d;
   logic [7:0]              cur_byte;
   logic                    accept;
   logic                    bit_end;

   // frame_q counts data frames still owed; zero means the control frame is on the line.
   assign cur_byte = (frame_q != '0) ? data_q[8*DATA_BYTES-1 -: 8] : ctl_q;
   assign accept   = (state_q == S_IDLE) && in_valid;
   assign in_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign sout     = sout_q;

   mtm_ser_bit_tick #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_bit_tick (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (accept),
      .en_i  (busy),
      .tick_o(bit_end)
   );

   // Next-state logic; sout_d is the value of the bit that starts after this edge.
   always_comb begin
      state_d   = state_q;
      sout_d    = sout_q;
      bit_idx_d = bit_idx_q;
      frame_d   = frame_q;
      gap_d     = gap_q;
      data_d    = data_q;
      ctl_d     = ctl_q;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            sout_d = STOP_BIT;
            if (in_valid) begin
               state_d = S_START;
               sout_d  = START_BIT;
               data_d  = in_data;
               ctl_d   = in_ctl;
               frame_d = in_ctl[CTL_ERR_BIT] ? '0 : FW'(DATA_BYTES);
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_FLAG;
               sout_d  = (frame_q != '0) ? FLAG_DATA : FLAG_CTL;
            end
         end
         S_FLAG: begin
            if (bit_end) begin
               state_d   = S_PAYLOAD;
               bit_idx_d = 3'd7;
               sout_d    = cur_byte[7];
            end
         end
         S_PAYLOAD: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd0) begin
`ifdef MTM_SER_PARITY_EN
                  state_d = S_PARITY;
                  sout_d  = even_parity(cur_byte);
`else
                  state_d = S_STOP;
                  sout_d  = STOP_BIT;
`endif
               end else begin
                  bit_idx_d = bit_idx_q - 3'd1;
                  sout_d    = cur_byte[bit_idx_d];
               end
            end
         end
`ifdef MTM_SER_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               sout_d  = STOP_BIT;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               if (frame_q != '0) begin
                  state_d = S_START;
                  sout_d  = START_BIT;
                  frame_d = frame_q - FW'(1);
                  data_d  = data_q << 8;
               end else if (IFG_BITS > 0) begin
                  state_d = S_GAP;
                  sout_d  = STOP_BIT;
                  gap_d   = '0;
               end else begin
                  state_d = S_IDLE;
                  sout_d  = STOP_BIT;
                  done    = 1'b1;
               end
            end
         end
         S_GAP: begin
            sout_d = STOP_BIT;
            if (bit_end) begin
               if (gap_q == GAP_LAST) begin
                  state_d = S_IDLE;
                  done    = 1'b1;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            sout_d  = STOP_BIT;
         end
      endcase
   end

   // State and datapath registers; reset drops any partial packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sout_q    <= STOP_BIT;
         bit_idx_q <= '0;
         frame_q   <= '0;
         gap_q     <= '0;
         data_q    <= '0;
         ctl_q     <= '0;
      end else begin
         state_q   <= state_d;
         sout_q    <= sout_d;
         bit_idx_q <= bit_idx_d;
         frame_q   <= frame_d;
         gap_q     <= gap_d;
         data_q    <= data_d;
         ctl_q     <= ctl_d;
      end
   end

endmodule

// File: doc/mtm_alu_pkt_serializer.md
# mtm_alu_pkt_serializer

- Parametrised packet serializer for the ALU result path.
- Takes a DATA_BYTES-wide result word and an 8-bit control byte through a valid/ready handshake.
- Emits them on a single-wire serial line as framed bytes at a configurable bit rate, with a configurable inter-packet gap.
- Sits between the ALU core and the chip's serial output pin.

## Interface
- DATA_BYTES, 4, number of data bytes per normal packet (≥1)
- CLK_PER_BIT, 1, clock cycles each serial bit is held (≥1)
- IFG_BITS, 0, idle (sout=1) bit times appended after each packet (≥0)
- clk  in  1  posedge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  result available
- in_ready  out  1  block can accept; high only in IDLE
- in_data  in  8*DATA_BYTES  result word; most-significant byte sent first
- in_ctl  in  8  control byte; bit 7 = 1 marks an error packet
- sout  out  1  serial line; idles high
- busy  out  1  packet in progress (start bit through end of gap)
- done  out  1  one-cycle pulse at packet completion

## Operation
- Frame: start bit 0, then flag bit (0 = data, 1 = control), then 8 payload bits MSB first, then stop bit 1. Frame length is 11 bits.
- Handshake: accepted on the edge where in_valid && in_ready. in_data and in_ctl are latched at that edge; later changes are ignored.
- Normal packet (in_ctl[7]=0): DATA_BYTES data frames, then one control frame carrying in_ctl. Total (DATA_BYTES+1)*11 bits.
- Error packet (in_ctl[7]=1): one control frame only, any code. Total 11 bits.
- FSM states and transitions:
  - IDLE: accept on handshake, go to START.
  - START → FLAG → PAYLOAD (8 bits) → [PARITY] → STOP.
  - STOP → START if frames remain.
  - STOP → GAP if IFG_BITS>0.
  - STOP → IDLE otherwise.
  - GAP → IDLE after IFG_BITS bit times.
- Counters:
  - bit-tick counter: 0..CLK_PER_BIT-1.
  - payload bit index: 7..0.
  - frame counter: DATA_BYTES..0.
  - gap counter.
  - All sized with $clog2 and never wrap during a valid packet.
- in_valid while busy: ignored (in_ready=0), no loss of the current packet.
- Reset (any time, including mid-frame):
  - Next edge forces IDLE, sout=1, busy=0, done=0, in_ready=1.
  - The partial packet is dropped with no done pulse.

## Timing
- Reset values: sout=1, busy=0, done=0, in_ready=1.
- sout is registered. On the acceptance edge, sout is driven 0 (start bit) and busy goes 1. Start bit is therefore visible the cycle after the handshake cycle.
- Each bit lasts exactly CLK_PER_BIT cycles.
- done is high during the last cycle of the packet: the last stop-bit cycle, or the last gap cycle if IFG_BITS>0.
- The next cycle returns to IDLE with busy=0 and in_ready=1.
- Minimum spacing between packets is 1 idle clock plus IFG_BITS bit times.
- Packet duration = total_bits*CLK_PER_BIT + IFG_BITS*CLK_PER_BIT cycles.

## Configuration
- MTM_SER_PARITY_EN defined:
  - An even-parity bit over the 8 payload bits is inserted between the payload and the stop bit.
  - Frame length becomes 12 bits; all totals scale accordingly.
- Not defined: 11-bit frame, no parity logic.

## Structure
- Package mtm_ser_pkg holds:
  - state enum;
  - START_BIT=0, STOP_BIT=1, FLAG_DATA=0, FLAG_CTL=1;
  - FRAME_BITS (11 or 12, chosen by the macro);
  - CTL_ERR_BIT=7.
- Sub-module mtm_ser_bit_tick: CLK_PER_BIT divider producing a one-cycle bit-end strobe. It is cleared on acceptance and on rst.

## Test plan
- DATA_BYTES=4, CLK_PER_BIT=1, in_data=32'h12345678, in_ctl=8'h0A:
  - sout = 0 0 00010010 1 | 0 0 00110100 1 | 0 0 01010110 1 | 0 0 01111000 1 | 0 1 00001010 1.
  - done pulses 55 cycles after acceptance.
- in_ctl=8'hC9, any in_data: only 0 1 11001001 1 (11 bits); done after 11 cycles; in_data never appears on sout.
- CLK_PER_BIT=3, same normal packet: every bit held 3 cycles; done at cycle 165; in_ready low throughout.
- IFG_BITS=2, in_valid held high with two packets: second start bit begins exactly 2 bit times + 1 clock after the first packet's stop bit; the changed in_data between packets is sent correctly.
- rst asserted in the 3rd data frame: the next cycle shows sout=1, busy=0, in_ready=1, with no done pulse; a fresh packet afterwards is sent complete.
- MTM_SER_PARITY_EN, byte 8'h12 → parity bit 0; byte 8'h34 → parity bit 1; frame length 12.
